// File: rtl/bfm_operand_scheduler.sv
// bfm_operand_scheduler
// Shares one bfm operand datapath between NUM_REQ requesters. A round-robin
// arbiter picks at most one operand pair per cycle and drives it onto
// A_s/B_s. Each issued pair is tagged with its requester ID, and the bfm
// result comes back with that tag RES_LAT cycles later. Issued pairs are
// counted per batch, and xmit_en_o toggles at every batch boundary.
//
// Handshake: requester k transfers a pair on a clock edge where
// req_valid_i[k] and req_ready_o[k] are both high. Once a requester raises
// valid, it keeps valid high and its operands stable until that edge.
// req_ready_o is a one-hot grant. It depends only on req_valid_i, the
// round-robin pointer and the FSM state, and never on the operands.
// Responses carry no backpressure: rsp_valid_o is a single-cycle pulse.
module bfm_operand_scheduler #(
    parameter int NUM_REQ    = 4,
    parameter int ITEM_WIDTH = 8,
    parameter int RES_WIDTH  = 8,
    parameter int RES_LAT    = 1,
    parameter int BATCH_LEN  = 100
) (
    input  logic                            clk_i,
    input  logic                            reset_ni,
    input  logic                            enable_i,
    input  logic [NUM_REQ-1:0]              req_valid_i,
    input  logic [NUM_REQ*ITEM_WIDTH-1:0]   req_a_i,
    input  logic [NUM_REQ*ITEM_WIDTH-1:0]   req_b_i,
    output logic [NUM_REQ-1:0]              req_ready_o,
    output logic [ITEM_WIDTH-1:0]           A_s,
    output logic [ITEM_WIDTH-1:0]           B_s,
    input  logic [RES_WIDTH-1:0]            res_i,
    output logic                            rsp_valid_o,
    output logic [$clog2(NUM_REQ)-1:0]      rsp_id_o,
    output logic [RES_WIDTH-1:0]            rsp_data_o,
    output logic                            xmit_en_o,
    output logic                            batch_done_o,
    output logic                            busy_o,
    output logic [1:0]                      dbg_state_o
);

    localparam int ID_W  = $clog2(NUM_REQ);
    localparam int CNT_W = (BATCH_LEN > 1) ? $clog2(BATCH_LEN) : 1;
    localparam int INF_W = $clog2(RES_LAT + 2);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    state_t               state_q;
    state_t               state_d;
    logic [ID_W-1:0]      ptr_q;
    logic [NUM_REQ-1:0]   grant;
    logic [ID_W-1:0]      grant_id;
    logic                 grant_found;
    logic [ID_W:0]        arb_sum;
    logic [ID_W-1:0]      arb_cand;
    logic                 fire;
    logic [RES_LAT-1:0]   tag_v_q;
    logic [ID_W-1:0]      tag_id_q [RES_LAT];
    logic [INF_W-1:0]     inflight_q;
    logic [CNT_W-1:0]     batch_cnt_q;
    logic                 pipe_empty;
    logic                 head_v;

    assign head_v      = tag_v_q[RES_LAT-1];
    assign pipe_empty  = (tag_v_q == '0) && (inflight_q == '0);
    assign dbg_state_o = state_q;

    // Round-robin search: the first valid requester at or above the pointer, wrapping.
    always_comb begin
        grant       = '0;
        grant_id    = '0;
        grant_found = 1'b0;
        arb_sum     = '0;
        arb_cand    = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            arb_sum = {1'b0, ptr_q} + (ID_W+1)'(i);
            if (arb_sum >= (ID_W+1)'(NUM_REQ)) begin
                arb_sum = arb_sum - (ID_W+1)'(NUM_REQ);
            end
            arb_cand = arb_sum[ID_W-1:0];
            if (!grant_found && req_valid_i[arb_cand]) begin
                grant[arb_cand] = 1'b1;
                grant_id        = arb_cand;
                grant_found     = 1'b1;
            end
        end
    end

    // Grants are offered only in RUN; IDLE and DRAIN present an all-zero ready.
    assign req_ready_o = (state_q == ST_RUN) ? grant : '0;
    assign fire        = (state_q == ST_RUN) && grant_found;

    // Next-state logic. A drain always runs to completion, even if enable returns.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE:  if (enable_i)   state_d = ST_RUN;
            ST_RUN:   if (!enable_i)  state_d = ST_DRAIN;
            ST_DRAIN: if (pipe_empty) state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // State register. busy_o tracks the registered state (low only in IDLE).
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            state_q <= ST_IDLE;
            busy_o  <= 1'b0;
        end else begin
            state_q <= state_d;
            busy_o  <= (state_d != ST_IDLE);
        end
    end

    // Operand launch and pointer update. Both hold when nothing fires.
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            A_s   <= '0;
            B_s   <= '0;
            ptr_q <= '0;
        end else if (fire) begin
            A_s   <= req_a_i[grant_id*ITEM_WIDTH +: ITEM_WIDTH];
            B_s   <= req_b_i[grant_id*ITEM_WIDTH +: ITEM_WIDTH];
            ptr_q <= (grant_id == ID_W'(NUM_REQ - 1)) ? '0 : grant_id + 1'b1;
        end
    end

    // Tag pipeline. A tag written at edge N sits at the head during the cycle
    // before edge N+RES_LAT, which is when the bfm result for it is on res_i.
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            tag_v_q <= '0;
            for (int s = 0; s < RES_LAT; s++) begin
                tag_id_q[s] <= '0;
            end
        end else begin
            tag_v_q[0]  <= fire;
            tag_id_q[0] <= grant_id;
            for (int s = 1; s < RES_LAT; s++) begin
                tag_v_q[s]  <= tag_v_q[s-1];
                tag_id_q[s] <= tag_id_q[s-1];
            end
        end
    end

    // In-flight count: pairs issued but not yet returned as a response.
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            inflight_q <= '0;
        end else begin
            unique case ({fire, head_v})
                2'b10:   inflight_q <= inflight_q + INF_W'(1);
                2'b01:   inflight_q <= inflight_q - INF_W'(1);
                default: inflight_q <= inflight_q;
            endcase
        end
    end

    // Response capture. The ID and data hold between pulses.
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            rsp_valid_o <= 1'b0;
            rsp_id_o    <= '0;
            rsp_data_o  <= '0;
        end else begin
            rsp_valid_o <= head_v;
            if (head_v) begin
                rsp_id_o   <= tag_id_q[RES_LAT-1];
                rsp_data_o <= res_i;
            end
        end
    end

    // Batch accounting. The count survives IDLE and DRAIN; only reset clears it.
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            batch_cnt_q  <= '0;
            xmit_en_o    <= 1'b0;
            batch_done_o <= 1'b0;
        end else begin
            batch_done_o <= 1'b0;
            if (fire) begin
                if (batch_cnt_q == CNT_W'(BATCH_LEN - 1)) begin
                    batch_cnt_q  <= '0;
                    xmit_en_o    <= ~xmit_en_o;
                    batch_done_o <= 1'b1;
                end else begin
                    batch_cnt_q <= batch_cnt_q + CNT_W'(1);
                end
            end
        end
    end

    // Structural invariants: the grant is one-hot, and the in-flight count is bounded by the pipeline depth.
    always_ff @(posedge clk_i) begin
        if (reset_ni) begin
            assert ($onehot0(req_ready_o));
            assert (inflight_q <= INF_W'(RES_LAT));
        end
    end

endmodule

// File: tb/tb_bfm_operand_scheduler.sv
// Bench for bfm_operand_scheduler: directed scenarios, a transaction-level
// reference model with an expected-response queue, and a per-cycle compare.
module tb_bfm_operand_scheduler;

    localparam int N     = 4;
    localparam int IW    = 8;
    localparam int RW    = 8;
    localparam int LAT   = 3;
    localparam int BL    = 4;
    localparam int IDW   = 2;
    localparam int EXP_W = 32 + IDW + 2*IW;

    // ---------------- clock / reset / DUT ----------------
    logic              clk_i       = 1'b0;
    logic              reset_ni    = 1'b0;
    logic              enable_i    = 1'b0;
    logic [N-1:0]      req_valid_i = '0;
    logic [N*IW-1:0]   req_a_i     = '0;
    logic [N*IW-1:0]   req_b_i     = '0;
    logic [N-1:0]      req_ready_o;
    logic [IW-1:0]     A_s;
    logic [IW-1:0]     B_s;
    logic [RW-1:0]     res_i;
    logic              rsp_valid_o;
    logic [IDW-1:0]    rsp_id_o;
    logic [RW-1:0]     rsp_data_o;
    logic              xmit_en_o;
    logic              batch_done_o;
    logic              busy_o;
    logic [1:0]        dbg_state_o;

    always #5 clk_i = ~clk_i;

    bfm_operand_scheduler #(
        .NUM_REQ(N), .ITEM_WIDTH(IW), .RES_WIDTH(RW), .RES_LAT(LAT), .BATCH_LEN(BL)
    ) dut (
        .clk_i(clk_i), .reset_ni(reset_ni), .enable_i(enable_i),
        .req_valid_i(req_valid_i), .req_a_i(req_a_i), .req_b_i(req_b_i),
        .req_ready_o(req_ready_o), .A_s(A_s), .B_s(B_s), .res_i(res_i),
        .rsp_valid_o(rsp_valid_o), .rsp_id_o(rsp_id_o), .rsp_data_o(rsp_data_o),
        .xmit_en_o(xmit_en_o), .batch_done_o(batch_done_o), .busy_o(busy_o),
        .dbg_state_o(dbg_state_o)
    );

    // bfm stand-in: res = 3*A + B, with LAT-1 register stages behind A_s/B_s.
    function automatic logic [RW-1:0] bfm_f(input logic [IW-1:0] a, input logic [IW-1:0] b);
        return RW'(32'(a) * 3 + 32'(b));
    endfunction

    logic [2*IW-1:0] bfm_p0 = '0;
    logic [2*IW-1:0] bfm_p1 = '0;
    always @(posedge clk_i) begin
        bfm_p0 <= {A_s, B_s};
        bfm_p1 <= bfm_p0;
    end
    assign res_i = bfm_f(bfm_p1[2*IW-1:IW], bfm_p1[IW-1:0]);

    // ---------------- check bookkeeping ----------------
    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    int              m_mode  = 0;      // 0 idle, 1 run, 2 drain
    int              m_ptr   = 0;
    int              m_fires = 0;
    int              m_cyc   = 0;
    int              m_g     = -1;
    logic            m_was_empty = 1'b1;
    logic [IW-1:0]   m_a     = '0;
    logic [IW-1:0]   m_b     = '0;
    logic            m_rv    = 1'b0;
    int              m_rid   = 0;
    logic [RW-1:0]   m_rdata = '0;
    logic            m_xmit  = 1'b0;
    logic            m_bd    = 1'b0;
    logic [N-1:0]    m_pending = '0;
    logic [EXP_W-1:0] m_e    = '0;
    logic [EXP_W-1:0] exp_q[$];

    function automatic int pick(input logic [N-1:0] v, input int ptr);
        for (int i = 0; i < N; i++) begin
            if (v[(ptr + i) % N]) return (ptr + i) % N;
        end
        return -1;
    endfunction

    initial begin
        forever begin
            @(posedge clk_i or negedge reset_ni);
            if (!reset_ni) begin
                m_mode = 0; m_ptr = 0; m_fires = 0;
                m_a = '0; m_b = '0; m_rv = 1'b0; m_rid = 0; m_rdata = '0;
                m_xmit = 1'b0; m_bd = 1'b0; m_pending = '0;
                exp_q.delete();
            end else begin
                m_cyc++;
                m_was_empty = (exp_q.size() == 0);
                for (int k = 0; k < N; k++) begin
                    if (m_pending[k]) chk("hold_valid", 32'(req_valid_i[k]), 32'(1));
                end
                m_g = (m_mode == 1) ? pick(req_valid_i, m_ptr) : -1;
                m_rv = 1'b0;
                if (exp_q.size() > 0 && int'(exp_q[0][EXP_W-1 -: 32]) == m_cyc) begin
                    m_e     = exp_q.pop_front();
                    m_rv    = 1'b1;
                    m_rid   = int'(m_e[2*IW +: IDW]);
                    m_rdata = bfm_f(m_e[IW +: IW], m_e[0 +: IW]);
                end
                m_bd = 1'b0;
                if (m_g >= 0) begin
                    m_a   = req_a_i[m_g*IW +: IW];
                    m_b   = req_b_i[m_g*IW +: IW];
                    m_ptr = (m_g + 1) % N;
                    exp_q.push_back({32'(m_cyc + LAT), IDW'(m_g), m_a, m_b});
                    m_fires++;
                    if (m_fires % BL == 0) begin
                        m_bd   = 1'b1;
                        m_xmit = ~m_xmit;
                    end
                end
                m_pending = req_valid_i & ~((m_g >= 0) ? (N'(1) << m_g) : N'(0));
                case (m_mode)
                    0: if (enable_i) m_mode = 1;
                    1: if (!enable_i) m_mode = 2;
                    2: if (m_was_empty) m_mode = 0;
                    default: m_mode = 0;
                endcase
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    initial begin
        int p;
        logic [31:0] exp_ready;
        @(posedge clk_i);
        forever begin
            @(negedge clk_i);
            p = pick(req_valid_i, m_ptr);
            exp_ready = (m_mode == 1 && p >= 0) ? (32'(1) << p) : 32'(0);
            chk("ready",      32'(req_ready_o),  exp_ready);
            chk("a_s",        32'(A_s),          32'(m_a));
            chk("b_s",        32'(B_s),          32'(m_b));
            chk("rsp_valid",  32'(rsp_valid_o),  32'(m_rv));
            if (m_rv) begin
                chk("rsp_id",   32'(rsp_id_o),   32'(m_rid));
                chk("rsp_data", 32'(rsp_data_o), 32'(m_rdata));
            end
            chk("xmit_en",    32'(xmit_en_o),    32'(m_xmit));
            chk("batch_done", 32'(batch_done_o), 32'(m_bd));
            chk("busy",       32'(busy_o),       32'(m_mode != 0));
        end
    end

    // ---------------- driver tasks ----------------
    logic [N-1:0] snap_ready = '0;
    logic [N-1:0] last_fired = '0;

    task automatic offer(input int k, input logic [IW-1:0] a, input logic [IW-1:0] b);
        req_valid_i[k]       = 1'b1;
        req_a_i[k*IW +: IW]  = a;
        req_b_i[k*IW +: IW]  = b;
    endtask

    // One clock: snapshot the grant, then retire fired requesters just after the edge.
    task automatic tick();
        @(negedge clk_i);
        snap_ready = req_ready_o;
        last_fired = req_valid_i & req_ready_o;
        @(posedge clk_i);
        #1;
        req_valid_i = req_valid_i & ~last_fired;
    endtask

    task automatic fire_one(input int k, input logic [IW-1:0] a, input logic [IW-1:0] b);
        offer(k, a, b);
        tick();
        chk("fire_one", 32'(last_fired), 32'(1) << k);
    endtask

    // ---------------- directed scenarios ----------------
    initial begin
        int bd_count;
        repeat (2) @(posedge clk_i);
        #1;
        chk("rst_ready", 32'(req_ready_o),  32'(0));
        chk("rst_a_s",   32'(A_s),          32'(0));
        chk("rst_rsp_v", 32'(rsp_valid_o),  32'(0));
        chk("rst_xmit",  32'(xmit_en_o),    32'(0));
        chk("rst_busy",  32'(busy_o),       32'(0));
        reset_ni = 1'b1;

        // 1: single requester, result returns LAT cycles after the fire
        enable_i = 1'b1;
        offer(0, 8'h03, 8'h05);
        tick();
        chk("t1_idle_ready", 32'(snap_ready), 32'(0));
        tick();
        chk("t1_ready", 32'(snap_ready), 32'h1);
        chk("t1_a_s",   32'(A_s), 32'h03);
        chk("t1_b_s",   32'(B_s), 32'h05);
        for (int i = 1; i <= LAT + 1; i++) begin
            tick();
            chk("t1_rsp_valid", 32'(rsp_valid_o), 32'(i == LAT));
            if (i == LAT) begin
                chk("t1_rsp_id",   32'(rsp_id_o),   32'(0));
                chk("t1_rsp_data", 32'(rsp_data_o), 32'h0E);
            end
        end

        // 2: all four continuously valid -> grants 0,1,2,3,0,1,2,3
        fire_one(3, 8'h21, 8'h22);
        for (int k = 0; k < N; k++) offer(k, 8'(8'h30 + k), 8'(8'h40 + k));
        for (int i = 0; i < 8; i++) begin
            tick();
            chk("t2_grant", 32'(snap_ready), 32'(1) << (i % 4));
            if (i < 7) offer(i % 4, 8'(8'h50 + i), 8'(8'h60 + i));
        end
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("t2_tail_grant", 32'(snap_ready), 32'(1) << i);
        end

        // 3: requesters 1 and 3, pointer at 2 -> 3, 1, 3
        fire_one(1, 8'h71, 8'h72);
        offer(1, 8'h81, 8'h82);
        offer(3, 8'h83, 8'h84);
        tick();
        chk("t3_g0", 32'(snap_ready), 32'b1000);
        offer(3, 8'h85, 8'h86);
        tick();
        chk("t3_g1", 32'(snap_ready), 32'b0010);
        offer(1, 8'h87, 8'h88);
        tick();
        chk("t3_g2", 32'(snap_ready), 32'b1000);
        tick();
        chk("t3_g3", 32'(snap_ready), 32'b0010);

        // 4: batch boundaries at the 4th and 8th fires of a fresh batch pair
        for (int j = 0; j < 6; j++) fire_one(j % 4, 8'(8'h90 + j), 8'(8'hA0 + j));
        chk("t4_xmit_start", 32'(xmit_en_o), 32'(0));
        bd_count = 0;
        for (int i = 1; i <= 8; i++) begin
            fire_one(i % 4, 8'(8'hB0 + i), 8'(8'hC0 + i));
            chk("t4_xmit", 32'(xmit_en_o), 32'(i >= 4 && i < 8));
            chk("t4_done", 32'(batch_done_o), 32'(i == 4 || i == 8));
            bd_count += int'(batch_done_o);
        end
        chk("t4_pulses", 32'(bd_count), 32'(2));

        // 5: drop enable with two pairs in flight
        repeat (4) tick();
        offer(0, 8'hD0, 8'hD1);
        offer(1, 8'hD2, 8'hD3);
        tick();
        tick();
        enable_i = 1'b0;
        tick();
        offer(2, 8'hE0, 8'hE1);
        for (int j = 3; j <= 7; j++) begin
            tick();
            chk("t5_ready",     32'(snap_ready),  32'(0));
            chk("t5_busy",      32'(busy_o),      32'(j < 5));
            chk("t5_rsp_valid", 32'(rsp_valid_o), 32'(j == 3 || j == 4));
        end
        enable_i = 1'b1;
        tick();
        chk("t5_idle_ready", 32'(snap_ready), 32'(0));
        tick();
        chk("t5_regrant", 32'(snap_ready), 32'b0100);

        // 6: asynchronous reset with pairs in flight
        offer(1, 8'hF1, 8'hF2);
        offer(3, 8'hF3, 8'hF4);
        tick();
        tick();
        offer(0, 8'h11, 8'h12);
        #2;
        reset_ni = 1'b0;
        #1;
        chk("t6_ready", 32'(req_ready_o),  32'(0));
        chk("t6_a_s",   32'(A_s),          32'(0));
        chk("t6_b_s",   32'(B_s),          32'(0));
        chk("t6_rsp_v", 32'(rsp_valid_o),  32'(0));
        chk("t6_rsp_id",32'(rsp_id_o),     32'(0));
        chk("t6_xmit",  32'(xmit_en_o),    32'(0));
        chk("t6_done",  32'(batch_done_o), 32'(0));
        chk("t6_busy",  32'(busy_o),       32'(0));
        req_valid_i = '0;
        enable_i    = 1'b0;
        @(posedge clk_i);
        #2;
        reset_ni = 1'b1;
        for (int j = 0; j < 4; j++) begin
            tick();
            chk("t6_no_rsp", 32'(rsp_valid_o), 32'(0));
        end
        offer(0, 8'h13, 8'h14);
        offer(2, 8'h15, 8'h16);
        enable_i = 1'b1;
        tick();
        tick();
        chk("t6_first_grant", 32'(snap_ready), 32'h1);
        tick();
        repeat (5) tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Time bound on the whole run.
    initial begin
        #200000;
        errors++;
        $display("FAIL watchdog actual=timeout expected=completion");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
